main_fsm: RTL and testbench

//  Multicycle main controller for the RV32I+FP datapath. Moore FSM sequencing

---
 rtl/main_fsm.sv | 230 +++++++++++++++++++++++
 tb/tb_main_fsm.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/main_fsm.sv
// Multicycle main controller for the RV32I+FP datapath.
// Moore sequencer for fetch/decode/execute/writeback. It adds memory wait
// states, a variable-latency FP handshake with a timeout, and a terminal
// illegal-op fault state.
module main_fsm #(
    parameter int unsigned FP_TIMEOUT  = 32,
    parameter int unsigned TMO_W       = 6,
    parameter int unsigned MEM_WAIT_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    input  logic       fp_done,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       FPStart,
    output logic       Illegal,
    output logic [3:0] state_o
);

    localparam int unsigned OP_W = 7;

    localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYP = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYP = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ  = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL  = 7'b1101111;
    localparam logic [OP_W-1:0] OP_LUI  = 7'b0110111;
    localparam logic [OP_W-1:0] OP_FP   = 7'b1010011;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11,
        FPSTART  = 4'd12,
        FPWAIT   = 4'd13,
        FPWB     = 4'd14,
        FAULT    = 4'd15
    } state_t;

    state_t           state;
    state_t           nextState;
    logic [TMO_W-1:0] fpCount;
    logic             memRdy;
    logic             fpTimeout;

    // Wait states can be disabled for an always-ready memory.
    assign memRdy    = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
    assign fpTimeout = (fpCount == TMO_W'(FP_TIMEOUT - 1));
    assign state_o   = state;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    // FP wait counter: cleared on start, advances every FPWAIT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpCount <= '0;
        end else if (state == FPSTART) begin
            fpCount <= '0;
        end else if (state == FPWAIT) begin
            fpCount <= fpCount + TMO_W'(1);
        end
    end

    // Next-state and state-decoded control outputs; strobes held low in reset.
    always_comb begin
        nextState = state;
        PCUpdate  = 1'b0;
        Branch    = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        FPStart   = 1'b0;
        Illegal   = 1'b0;

        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = memRdy;
                PCUpdate  = memRdy;
                if (memRdy) nextState = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_RTYP:      nextState = EXECR;
                    OP_ITYP:      nextState = EXECI;
                    OP_BEQ:       nextState = BEQ;
                    OP_JAL:       nextState = JAL;
                    OP_LUI:       nextState = LUI;
                    OP_FP:        nextState = FPSTART;
                    default:      nextState = FAULT;
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                nextState = (op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (memRdy) nextState = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                nextState = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (memRdy) nextState = FETCH;
            end
            EXECR: begin
                ALUSrcA   = 2'b10;
                ALUOp     = 2'b10;
                nextState = ALUWB;
            end
            EXECI: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ALUOp     = 2'b10;
                nextState = ALUWB;
            end
            ALUWB: begin
                RegWrite  = 1'b1;
                nextState = FETCH;
            end
            BEQ: begin
                ALUSrcA   = 2'b10;
                ALUOp     = 2'b01;
                Branch    = 1'b1;
                nextState = FETCH;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                PCUpdate  = 1'b1;
                nextState = ALUWB;
            end
            LUI: begin
                ALUSrcA   = 2'b11;
                ALUSrcB   = 2'b01;
                nextState = ALUWB;
            end
            FPSTART: begin
                FPStart   = 1'b1;
                ALUOp     = 2'b11;
                nextState = FPWAIT;
            end
            FPWAIT: begin
                ALUOp = 2'b11;
                // A result arriving on the last allowed cycle still wins.
                if (fp_done) begin
                    nextState = FPWB;
                end else if (fpTimeout) begin
                    nextState = FAULT;
                end
            end
            FPWB: begin
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
                ALUOp     = 2'b11;
                nextState = FETCH;
            end
            FAULT: begin
                Illegal   = 1'b1;
                nextState = FAULT;
            end
            default: nextState = FAULT;
        endcase

        if (!reset) begin
            PCUpdate = 1'b0;
            Branch   = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            FPStart  = 1'b0;
        end
    end

    // Immediate format selected straight from the opcode.
    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OP_SW:   ImmSrc = 3'b001;
            OP_BEQ:  ImmSrc = 3'b010;
            OP_JAL:  ImmSrc = 3'b011;
            OP_LUI:  ImmSrc = 3'b100;
            default: ImmSrc = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: default instance plus a short-timeout instance.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       memReady;
    logic       fpDone;

    logic       PCUpdate, Branch, AdrSrc, IRWrite, MemWrite, RegWrite, FPStart, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic [3:0] state;

    logic       tPCUpdate, tBranch, tAdrSrc, tIRWrite, tMemWrite, tRegWrite, tFPStart, tIllegal;
    logic [1:0] tResultSrc, tALUSrcA, tALUSrcB, tALUOp;
    logic [2:0] tImmSrc;
    logic [3:0] tState;

    logic [5:0] strobes;
    assign strobes = {PCUpdate, Branch, IRWrite, MemWrite, RegWrite, FPStart};

    int checks = 0;
    int errors = 0;

    main_fsm dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(memReady), .fp_done(fpDone),
        .PCUpdate(PCUpdate), .Branch(Branch), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
        .FPStart(FPStart), .Illegal(Illegal), .state_o(state)
    );

    main_fsm #(.FP_TIMEOUT(4), .TMO_W(3), .MEM_WAIT_EN(1)) dutTmo (
        .clk(clk), .reset(reset), .op(op), .mem_ready(memReady), .fp_done(fpDone),
        .PCUpdate(tPCUpdate), .Branch(tBranch), .AdrSrc(tAdrSrc), .IRWrite(tIRWrite),
        .MemWrite(tMemWrite), .RegWrite(tRegWrite), .ResultSrc(tResultSrc),
        .ALUSrcA(tALUSrcA), .ALUSrcB(tALUSrcB), .ALUOp(tALUOp), .ImmSrc(tImmSrc),
        .FPStart(tFPStart), .Illegal(tIllegal), .state_o(tState)
    );

    always #5 clk = ~clk;

    // Single comparison point for every check.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset    = 1'b0;
        memReady = 1'b0;
        fpDone   = 1'b0;
        tick();
        reset = 1'b1;
        #1;
    endtask

    // Run one instruction with mem_ready=1, checking the state each cycle.
    task automatic runSeq(input string tag, input logic [6:0] opc,
                          input logic [19:0] seq, input int n);
        doReset();
        op       = opc;
        memReady = 1'b1;
        #1;
        for (int i = 0; i < n; i++) begin
            chk(tag, 32'(state), 32'(seq[4*i +: 4]));
            tick();
        end
    endtask

    initial begin
        int cnt;
        logic [6:0]  immOps [5];
        logic [2:0]  immExp [5];

        reset = 1'b0; op = 7'b0; memReady = 1'b1; fpDone = 1'b0;
        #2;
        // Reset state: strobes forced low even with mem_ready high in FETCH.
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_strobes", 32'(strobes), 32'd0);
        chk("rst_illegal", 32'(Illegal), 32'd0);
        chk("rst_muxes", {24'd0, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc[0]},
            {24'd0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0});
        chk("rst_resultsrc", 32'(ResultSrc), 32'd2);

        // Immediate format decode.
        immOps = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111};
        immExp = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
        for (int i = 0; i < 5; i++) begin
            op = immOps[i];
            #1;
            chk("immsrc", 32'(ImmSrc), 32'(immExp[i]));
        end

        // Reset asserted mid-MEMREAD.
        doReset();
        op = 7'b0000011; memReady = 1'b1;
        #1;
        chk("fetch_irwrite", 32'(IRWrite), 32'd1);
        chk("fetch_pcupdate", 32'(PCUpdate), 32'd1);
        tick(); tick();
        memReady = 1'b0;
        tick();
        chk("lw_memread", 32'(state), 32'd3);
        chk("memread_adrsrc", 32'(AdrSrc), 32'd1);
        reset = 1'b0; memReady = 1'b1;
        #1;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_strobes", 32'(strobes), 32'd0);
        tick();
        chk("midrst_state2", 32'(state), 32'd0);
        chk("midrst_strobes2", 32'(strobes), 32'd0);
        chk("midrst_illegal", 32'(Illegal), 32'd0);
        reset = 1'b1;

        // R-type add: 0,1,6,8,0 with RegWrite only in ALUWB.
        doReset();
        op = 7'b0110011; memReady = 1'b1;
        #1;
        chk("add_s0", 32'(state), 32'd0);
        chk("add_rw0", 32'(RegWrite), 32'd0);
        tick(); chk("add_s1", 32'(state), 32'd1); chk("add_rw1", 32'(RegWrite), 32'd0);
        tick(); chk("add_s6", 32'(state), 32'd6); chk("add_rw6", 32'(RegWrite), 32'd0);
        chk("add_aluop", 32'(ALUOp), 32'd2);
        tick(); chk("add_s8", 32'(state), 32'd8); chk("add_rw8", 32'(RegWrite), 32'd1);
        tick(); chk("add_s0b", 32'(state), 32'd0); chk("add_rw0b", 32'(RegWrite), 32'd0);

        // Other instruction paths (sequences listed LSB-first).
        runSeq("addi_seq", 7'b0010011, 20'h08710, 5);
        runSeq("lui_seq",  7'b0110111, 20'h08B10, 5);
        runSeq("jal_seq",  7'b1101111, 20'h08A10, 5);
        runSeq("beq_seq",  7'b1100011, 20'h00910, 4);

        // BEQ asserts Branch and subtracts.
        doReset();
        op = 7'b1100011; memReady = 1'b1;
        tick(); tick();
        chk("beq_branch", 32'(Branch), 32'd1);
        chk("beq_aluop", 32'(ALUOp), 32'd1);

        // lw with mem_ready low for 3 MEMREAD cycles.
        doReset();
        op = 7'b0000011; memReady = 1'b1;
        tick(); tick();
        chk("lw_memadr", 32'(state), 32'd2);
        memReady = 1'b0;
        cnt = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (state == 4'd3) cnt++;
            tick();
        end
        if (state == 4'd3) cnt++;
        chk("lw_hold", 32'(cnt), 32'd4);
        memReady = 1'b1;
        tick();
        chk("lw_memwb", 32'(state), 32'd4);
        chk("lw_rw", 32'(RegWrite), 32'd1);
        chk("lw_rsrc", 32'(ResultSrc), 32'd1);
        tick();
        chk("lw_fetch", 32'(state), 32'd0);
        chk("lw_rw_off", 32'(RegWrite), 32'd0);

        // sw with mem_ready delayed 2 cycles.
        doReset();
        op = 7'b0100011; memReady = 1'b1;
        tick(); tick();
        memReady = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (MemWrite) cnt++;
        end
        memReady = 1'b1;
        tick();
        chk("sw_memwrite_cycles", 32'(cnt), 32'd3);
        chk("sw_fetch", 32'(state), 32'd0);
        chk("sw_memwrite_off", 32'(MemWrite), 32'd0);

        // FP op, fp_done five cycles after FPStart.
        doReset();
        op = 7'b1010011; memReady = 1'b1;
        fpDone = 1'b1;
        tick();
        fpDone = 1'b0;
        tick();
        chk("fp_start_state", 32'(state), 32'd12);
        chk("fp_start_aluop", 32'(ALUOp), 32'd3);
        cnt = int'(FPStart);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (FPStart) cnt++;
            chk("fp_wait", 32'(state), 32'd13);
        end
        fpDone = 1'b1;
        tick();
        fpDone = 1'b0;
        chk("fp_pulses", 32'(cnt), 32'd1);
        chk("fp_wb", 32'(state), 32'd14);
        chk("fp_rsrc", 32'(ResultSrc), 32'd3);
        chk("fp_rw", 32'(RegWrite), 32'd1);
        tick();
        chk("fp_fetch", 32'(state), 32'd0);

        // FP timeout on the 4-cycle instance.
        doReset();
        op = 7'b1010011; memReady = 1'b1;
        tick(); tick();
        for (int i = 0; i < 4; i++) tick();
        chk("tmo_lastwait", 32'(tState), 32'd13);
        tick();
        chk("tmo_fault", 32'(tState), 32'd15);
        chk("tmo_illegal", 32'(tIllegal), 32'd1);
        chk("tmo_long_waits", 32'(state), 32'd13);
        fpDone = 1'b1;
        tick(); tick();
        fpDone = 1'b0;
        chk("tmo_sticky", 32'(tIllegal), 32'd1);
        chk("tmo_stay", 32'(tState), 32'd15);

        // Illegal opcode -> terminal FAULT.
        doReset();
        op = 7'b1111111; memReady = 1'b1;
        tick();
        chk("ill_decode", 32'(state), 32'd1);
        tick();
        chk("ill_fault", 32'(state), 32'd15);
        chk("ill_flag", 32'(Illegal), 32'd1);
        fpDone = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("ill_stay", 32'(state), 32'd15);
        chk("ill_strobes", 32'(strobes), 32'd0);
        fpDone = 1'b0;
        reset = 1'b0;
        #1;
        chk("ill_clear", 32'(Illegal), 32'd0);
        chk("ill_clear_state", 32'(state), 32'd0);
        reset = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
